// File: rtl/addr8s_pkg.sv
// Shared encodings and widths for the signed 8-bit adder fault monitor.
package addr8s_pkg;

    localparam int OP_W  = 8;
    localparam int SUM_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/addr8s_fault_monitor_if.sv
// Vector-in / checked-result-out handshake bundle of the fault monitor.
interface addr8s_fault_monitor_if;
    import addr8s_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [SUM_W-1:0] sum_dut;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] err_bits;
    logic             mismatch;

    modport master (
        output in_valid, a, b, sum_dut, out_ready,
        input  in_ready, out_valid, err_bits, mismatch
    );

    modport slave (
        input  in_valid, a, b, sum_dut, out_ready,
        output in_ready, out_valid, err_bits, mismatch
    );

endinterface

// File: rtl/addr8s_golden.sv
// Reference signed adder: sign-extends both operands to 9 bits and adds modulo 2^9.
module addr8s_golden
    import addr8s_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [SUM_W-1:0] sum
);

    assign sum = {a[OP_W-1], a} + {b[OP_W-1], b};

endmodule

// File: rtl/addr8s_fault_monitor.sv
// Two-stage checker comparing an external adder's O[8:0] against a golden sum,
// with saturating event counters, sticky error flag and halt-on-error control.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no vector accepted since reset/clear
//   RUN     | vectors flowing
//   HALT    | a mismatch was delivered with halt_on_err; input blocked, pipe drains
module addr8s_fault_monitor
    import addr8s_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    addr8s_fault_monitor_if.slave  bus,
    input  logic                   halt_on_err,
    input  logic                   clear,
    output logic [CNT_W-1:0]       vec_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic                   sticky_err,
    output logic [1:0]             state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_a_q, s1_a_d;
    logic [OP_W-1:0]  s1_b_q, s1_b_d;
    logic [SUM_W-1:0] s1_sum_q, s1_sum_d;
    logic             s2_valid_q, s2_valid_d;
    logic [SUM_W-1:0] err_bits_q, err_bits_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             sticky_q, sticky_d;
    state_e           state_q, state_d;

    logic             out_hs, in_hs, s1_adv, s1_free, s2_free, in_ready_int;
    logic [SUM_W-1:0] golden_sum;
    logic [SUM_W-1:0] diff;

    addr8s_golden u_golden (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .sum (golden_sum)
    );

    always_comb begin
        s2_free      = !s2_valid_q || bus.out_ready;
        out_hs       = s2_valid_q && bus.out_ready;
        s1_adv       = s1_valid_q && s2_free;
        s1_free      = !s1_valid_q || s2_free;
        in_ready_int = rst_n && s1_free && (state_q != ST_HALT);
        in_hs        = bus.in_valid && in_ready_int;
        diff         = s1_sum_q ^ golden_sum;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        err_bits_d = err_bits_q;
        mismatch_d = mismatch_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        sticky_d   = sticky_q;
        state_d    = state_q;

        if (in_hs) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.a;
            s1_b_d     = bus.b;
            s1_sum_d   = bus.sum_dut;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Result registers only change on a fresh load, so they stay stable under stall.
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            err_bits_d = diff;
            mismatch_d = |diff;
        end else if (out_hs) begin
            s2_valid_d = 1'b0;
        end

        if (clear) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
            sticky_d  = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            if (out_hs) begin
                if (vec_cnt_q != CNT_MAX) vec_cnt_d = vec_cnt_q + CNT_ONE;
                if (mismatch_q) begin
                    if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
                    sticky_d = 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: if (in_hs) state_d = ST_RUN;
                ST_RUN:  if (out_hs && mismatch_q && halt_on_err) state_d = ST_HALT;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            err_bits_q <= '0;
            mismatch_q <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            sticky_q   <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            err_bits_q <= err_bits_d;
            mismatch_q <= mismatch_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            sticky_q   <= sticky_d;
            state_q    <= state_d;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid_q;
    assign bus.err_bits  = err_bits_q;
    assign bus.mismatch  = mismatch_q;
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign sticky_err    = sticky_q;
    assign state         = state_q;

endmodule

// File: tb/tb_addr8s_fault_monitor.sv
// Bench for addr8s_fault_monitor: queue-based reference model plus directed scenarios,
// driving a 16-bit-counter instance and a 4-bit-counter instance in lockstep.
module tb_addr8s_fault_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, halt_on_err, clear;
    logic [7:0] a, b;
    logic [8:0] sum_dut;

    logic [15:0] vec_cnt, err_cnt;
    logic [3:0]  vec4, err4;
    logic        sticky, sticky4;
    logic [1:0]  state, state4;

    addr8s_fault_monitor_if bus ();
    addr8s_fault_monitor_if bus4 ();

    assign bus.in_valid   = in_valid;
    assign bus.a          = a;
    assign bus.b          = b;
    assign bus.sum_dut    = sum_dut;
    assign bus.out_ready  = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.a         = a;
    assign bus4.b         = b;
    assign bus4.sum_dut   = sum_dut;
    assign bus4.out_ready = out_ready;

    addr8s_fault_monitor #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .halt_on_err(halt_on_err), .clear(clear),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .sticky_err(sticky), .state(state)
    );

    addr8s_fault_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .halt_on_err(halt_on_err), .clear(clear),
        .vec_cnt(vec4), .err_cnt(err4), .sticky_err(sticky4), .state(state4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [8:0] err;
        int         age;
    } item_t;

    item_t q[$];
    int    m_vec, m_err, m_state;
    bit    m_sticky, m_ih, m_oh, m_mis;

    function automatic logic [8:0] gold(input logic [7:0] x, input logic [7:0] y);
        int gx, gy;
        gx = (x > 8'd127) ? int'(x) - 256 : int'(x);
        gy = (y > 8'd127) ? int'(y) - 256 : int'(y);
        return 9'((gx + gy) & 511);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit m_presented();
        return (q.size() > 0) && (q[0].age >= 2);
    endfunction

    // Two slots of capacity: a full pipe only takes a vector while one leaves.
    function automatic bit m_in_ready();
        return rst_n && (m_state != 2) && ((q.size() < 2) || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_vec = 0; m_err = 0; m_sticky = 0; m_state = 0;
        end else begin
            m_ih  = in_valid && m_in_ready();
            m_oh  = m_presented() && out_ready;
            m_mis = m_oh && (q[0].err != 9'd0);
            if (clear) begin
                m_vec = 0; m_err = 0; m_sticky = 0; m_state = 0;
            end else begin
                if (m_oh) begin
                    m_vec++;
                    if (m_mis) begin
                        m_err++;
                        m_sticky = 1;
                    end
                end
                if (m_state == 0 && m_ih) m_state = 1;
                else if (m_state == 1 && m_mis && halt_on_err) m_state = 2;
            end
            if (m_oh) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (m_ih) q.push_back('{err: sum_dut ^ gold(a, b), age: 1});
        end
    end

    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, m_in_ready());
        chk("out_valid", bus.out_valid, m_presented());
        chk("state", state, m_state);
        chk("vec_cnt", vec_cnt, sat(m_vec, 16));
        chk("err_cnt", err_cnt, sat(m_err, 16));
        chk("sticky_err", sticky, m_sticky);
        chk("in_ready4", bus4.in_ready, m_in_ready());
        chk("out_valid4", bus4.out_valid, m_presented());
        chk("vec_cnt4", vec4, sat(m_vec, 4));
        chk("err_cnt4", err4, sat(m_err, 4));
        if (m_presented()) begin
            chk("err_bits", bus.err_bits, q[0].err);
            chk("mismatch", bus.mismatch, q[0].err != 9'd0);
            chk("err_bits4", bus4.err_bits, q[0].err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic [8:0] ss);
        in_valid = v; a = aa; b = bb; sum_dut = ss;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    logic [7:0] ta [6];
    logic [7:0] tb_ [6];
    logic [8:0] ts [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, acc, guard;
        bit hs;
        ta  = '{8'h03, 8'h80, 8'h7F, 8'h81, 8'h00, 8'hC0};
        tb_ = '{8'h04, 8'h7F, 8'h7F, 8'h81, 8'h00, 8'h40};
        ts  = '{9'h007, 9'h1FF, 9'h0FE, 9'h103, 9'h000, 9'h000};

        rst_n = 0; in_valid = 0; out_ready = 1; halt_on_err = 0; clear = 0;
        a = 0; b = 0; sum_dut = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        chk("rst_state", state, 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // 0x7F + 0x01 = 0x080, correct
        tick(); vec(1, 8'h7F, 8'h01, 9'h080);
        tick(); in_valid = 0;
        @(negedge clk); chk("lat1_out_valid", bus.out_valid, 0);
        tick();
        @(negedge clk);
        chk("t36_out_valid", bus.out_valid, 1);
        chk("t36_err_bits", bus.err_bits, 9'h000);
        chk("t36_mismatch", bus.mismatch, 0);
        @(negedge clk);
        chk("t36_vec_cnt", vec_cnt, 1);
        chk("t36_state", state, 1);

        // 0x80 + 0x80 = 0x100, adder reports 0x000
        tick(); vec(1, 8'h80, 8'h80, 9'h000);
        tick(); in_valid = 0;
        tick();
        @(negedge clk);
        chk("t37_err_bits", bus.err_bits, 9'h100);
        chk("t37_mismatch", bus.mismatch, 1);
        @(negedge clk);
        chk("t37_err_cnt", err_cnt, 1);
        chk("t37_sticky", sticky, 1);
        chk("t37_vec_cnt", vec_cnt, 2);

        tick(); clear = 1; halt_on_err = 1;
        tick(); clear = 0;
        @(negedge clk);
        chk("clr_vec_cnt", vec_cnt, 0);
        chk("clr_sticky", sticky, 0);
        chk("clr_state", state, 0);

        // halt on second vector; one bubble, then third enters before halt lands
        tick(); vec(1, 8'h01, 8'h02, 9'h003);
        tick(); vec(1, 8'hFF, 8'hFF, 9'h1FF);
        tick(); in_valid = 0;
        tick(); vec(1, 8'h10, 8'h20, 9'h030);
        @(negedge clk);
        chk("t38_err_bits", bus.err_bits, 9'h001);
        chk("t38_mismatch", bus.mismatch, 1);
        tick(); vec(1, 8'h05, 8'h05, 9'h00A);
        @(negedge clk);
        chk("t38_state_halt", state, 2);
        chk("t38_in_ready", bus.in_ready, 0);
        tick();
        @(negedge clk);
        chk("t38_drain_valid", bus.out_valid, 1);
        tick(); tick();
        @(negedge clk);
        chk("t38_vec_cnt", vec_cnt, 3);
        chk("t38_err_cnt", err_cnt, 1);
        chk("t38_in_ready_held", bus.in_ready, 0);
        chk("t38_state_held", state, 2);
        tick(); in_valid = 0; clear = 1; halt_on_err = 0;
        tick(); clear = 0;
        @(negedge clk);
        chk("t38_clr_state", state, 0);
        chk("t38_clr_vec", vec_cnt, 0);
        chk("t38_clr_err", err_cnt, 0);
        chk("t38_clr_in_ready", bus.in_ready, 1);

        // stall 5 cycles with continuous in_valid
        tick();
        k = 0; acc = 0;
        out_ready = 0;
        for (int c = 0; c < 5; c++) begin
            vec(1, ta[k], tb_[k], ts[k]);
            @(negedge clk); hs = bus.in_ready;
            tick();
            if (hs) begin k++; acc++; end
        end
        chk("t39_accepted", acc, 2);
        out_ready = 1;
        guard = 0;
        while (k < 6 && guard < 50) begin
            vec(1, ta[k], tb_[k], ts[k]);
            @(negedge clk); hs = bus.in_ready;
            tick();
            if (hs) k++;
            guard++;
        end
        in_valid = 0;
        chk("t39_all_sent", k, 6);
        drain();
        @(negedge clk);
        chk("t39_vec_cnt", vec_cnt, 6);
        chk("t39_err_cnt", err_cnt, 1);

        // saturation with 20 mismatching vectors
        tick(); clear = 1;
        tick(); clear = 0;
        k = 0; guard = 0;
        while (k < 20 && guard < 100) begin
            vec(1, 8'(k), 8'h01, gold(8'(k), 8'h01) ^ 9'h004);
            @(negedge clk); hs = bus.in_ready;
            tick();
            if (hs) k++;
            guard++;
        end
        in_valid = 0;
        drain();
        @(negedge clk);
        chk("t40_vec4", vec4, 15);
        chk("t40_err4", err4, 15);
        chk("t40_vec16", vec_cnt, 20);
        chk("t40_err16", err_cnt, 20);

        // async reset with pipeline full
        tick(); out_ready = 0; vec(1, 8'h11, 8'h22, 9'h033);
        tick(); vec(1, 8'h12, 8'h22, 9'h034);
        tick(); in_valid = 0;
        @(negedge clk);
        chk("t41_full_valid", bus.out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("t41_rst_out_valid", bus.out_valid, 0);
        chk("t41_rst_err_bits", bus.err_bits, 0);
        chk("t41_rst_mismatch", bus.mismatch, 0);
        chk("t41_rst_vec_cnt", vec_cnt, 0);
        chk("t41_rst_err4", err4, 0);
        chk("t41_rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        tick();
        rst_n = 1; out_ready = 1;
        vec(1, 8'hF0, 8'h20, 9'h010);
        @(negedge clk); chk("t41_ready_first", bus.in_ready, 1);
        tick(); in_valid = 0;
        @(negedge clk); chk("t41_lat1", bus.out_valid, 0);
        tick();
        @(negedge clk);
        chk("t41_lat2", bus.out_valid, 1);
        chk("t41_err_bits", bus.err_bits, 9'h000);
        tick(); tick();
        @(negedge clk);
        chk("t41_vec_cnt", vec_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
